// File: rtl/spi_slave_core.sv
// spi_slave_core
//   SPI slave with all four CPOL/CPHA modes and a parametrised word width.
//   The SPI pins are oversampled in the system clock domain. The core gives
//   user logic a buffered TX word with a load handshake, a received word
//   marked by a one-cycle valid pulse, and pulsed error flags.
//
// Ports
//   clock        system clock, must run at least 4x the SCLK rate
//   reset_n      asynchronous active-low reset
//   sclk/ss_n/mosi  asynchronous SPI inputs from the master
//   miso/miso_oe slave data out and pad output enable
//   tx_data/tx_load/tx_ready  TX holding-register write handshake
//   rx_data/rx_valid          last complete received word and its update pulse
//   frame_err    pulse: ss_n released part-way through a word
//   tx_underrun  pulse: a word started while the holding register was empty
module spi_slave_core #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter bit          CPOL        = 1'b0,
    parameter bit          CPHA        = 1'b0,
    parameter bit          MSB_FIRST   = 1'b1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  sclk,
    input  logic                  ss_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_load,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  frame_err,
    output logic                  tx_underrun
);

    localparam int unsigned CW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
    logic                   sclk_prev, ss_prev;
    logic                   sclk_s, ss_s, mosi_s;

    logic [DATA_WIDTH-1:0]  hold;
    logic [DATA_WIDTH-1:0]  tx_shift, tx_shift_nxt;
    logic [DATA_WIDTH-1:0]  rx_shift, rx_next;
    logic [CW-1:0]          bit_cnt;
    logic                   first;

    logic lead_edge, trail_edge, sample_edge, shift_edge;
    logic ss_fall, ss_rise;
    logic frame_start, abort, sample_en, shift_en, word_done, reload;

    // Input synchronisers plus one extra flop on sclk/ss_n for edge detection.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync <= {SYNC_STAGES{CPOL}};
            ss_sync   <= '1;
            mosi_sync <= '0;
            sclk_prev <= CPOL;
            ss_prev   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_prev <= sclk_sync[SYNC_STAGES-1];
            ss_prev   <= ss_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign ss_s   = ss_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    assign lead_edge   = (sclk_s != CPOL) && (sclk_prev == CPOL);
    assign trail_edge  = (sclk_s == CPOL) && (sclk_prev != CPOL);
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge  : trail_edge;
    assign ss_fall     = ss_prev && !ss_s;
    assign ss_rise     = !ss_prev && ss_s;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ss_n release takes priority over a coincident sample edge.
    always_comb begin
        state_nxt   = state;
        frame_start = 1'b0;
        abort       = 1'b0;
        sample_en   = 1'b0;
        shift_en    = 1'b0;
        case (state)
            IDLE: begin
                if (ss_fall) begin
                    state_nxt   = ACTIVE;
                    frame_start = 1'b1;
                end
            end
            ACTIVE: begin
                if (ss_rise) begin
                    state_nxt = IDLE;
                    abort     = 1'b1;
                end else begin
                    sample_en = sample_edge;
                    shift_en  = shift_edge;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign word_done = sample_en && (bit_cnt == LAST_BIT);
    assign reload    = frame_start || word_done;

    always_comb begin
        rx_next      = '0;
        tx_shift_nxt = '0;
        if (MSB_FIRST) begin
            rx_next      = {rx_shift[DATA_WIDTH-2:0], mosi_s};
            tx_shift_nxt = {tx_shift[DATA_WIDTH-2:0], 1'b0};
        end else begin
            rx_next      = {mosi_s, rx_shift[DATA_WIDTH-1:1]};
            tx_shift_nxt = {1'b0, tx_shift[DATA_WIDTH-1:1]};
        end
    end

    // 'first' suppresses the shift edge that immediately follows a load:
    // in CPHA=1 the first leading edge only presents bit 0, and after a
    // back-to-back reload the trailing edge of the old word's last bit
    // (CPHA=0) or the new word's first leading edge (CPHA=1) must not shift.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hold        <= '0;
            tx_ready    <= 1'b1;
            tx_shift    <= '0;
            rx_shift    <= '0;
            rx_data     <= '0;
            bit_cnt     <= '0;
            first       <= 1'b0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            tx_underrun <= 1'b0;

            // A reload consumes the old holding state; a coincident accepted
            // load is then kept for the following word.
            if (reload && !tx_ready) begin
                tx_ready <= 1'b1;
            end
            if (tx_load && tx_ready) begin
                hold     <= tx_data;
                tx_ready <= 1'b0;
            end

            if (reload) begin
                tx_shift    <= tx_ready ? '0 : hold;
                tx_underrun <= tx_ready;
                first       <= frame_start ? CPHA : 1'b1;
            end else if (shift_en) begin
                if (first) begin
                    first <= 1'b0;
                end else begin
                    tx_shift <= tx_shift_nxt;
                end
            end

            if (frame_start) begin
                rx_shift <= '0;
                bit_cnt  <= '0;
            end else if (abort) begin
                bit_cnt   <= '0;
                frame_err <= (bit_cnt != '0);
            end else if (sample_en) begin
                rx_shift <= rx_next;
                if (word_done) begin
                    bit_cnt  <= '0;
                    rx_data  <= rx_next;
                    rx_valid <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

    assign miso_oe = (state == ACTIVE);
    assign miso    = (state == ACTIVE) ?
                     (MSB_FIRST ? tx_shift[DATA_WIDTH-1] : tx_shift[0]) : 1'b0;

endmodule

// File: tb/tb_spi_slave_core.sv
// tb_spi_slave_core
//   Drives three slave configurations from one bit-banged master:
//   a: 8-bit mode 0 MSB first, b: 8-bit mode 3 MSB first,
//   c: 16-bit mode 0 LSB first. Each slave has its own ss_n; sclk and mosi
//   are shared (idle slaves ignore sclk). Expected RX words are queued when
//   a frame is driven and popped when rx_valid is seen.
module tb_spi_slave_core;

    localparam int HALF = 8;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic        sclk    = 1'b0;
    logic        mosi    = 1'b0;
    logic [2:0]  ss_n    = '1;
    logic [2:0]  tx_load = '0;
    logic [7:0]  tx_a    = '0;
    logic [7:0]  tx_b    = '0;
    logic [15:0] tx_c    = '0;

    logic        miso_a, miso_b, miso_c;
    logic        oe_a, oe_b, oe_c;
    logic        rdy_a, rdy_b, rdy_c;
    logic [7:0]  rx_a, rx_b;
    logic [15:0] rx_c;
    logic        rxv_a, rxv_b, rxv_c;
    logic        ferr_a, ferr_b, ferr_c;
    logic        urun_a, urun_b, urun_c;

    int n_tests = 0;
    int n_fail  = 0;
    int rxv_cnt[3];
    int ferr_cnt[3];
    int urun_cnt[3];

    logic [15:0] q_a[$];
    logic [15:0] q_b[$];
    logic [15:0] q_c[$];

    always #5 clock = ~clock;

    spi_slave_core #(.DATA_WIDTH(8), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1), .SYNC_STAGES(2)) u_a (
        .clock(clock), .reset_n(reset_n), .sclk(sclk), .ss_n(ss_n[0]), .mosi(mosi),
        .miso(miso_a), .miso_oe(oe_a), .tx_data(tx_a), .tx_load(tx_load[0]), .tx_ready(rdy_a),
        .rx_data(rx_a), .rx_valid(rxv_a), .frame_err(ferr_a), .tx_underrun(urun_a));

    spi_slave_core #(.DATA_WIDTH(8), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b1), .SYNC_STAGES(2)) u_b (
        .clock(clock), .reset_n(reset_n), .sclk(sclk), .ss_n(ss_n[1]), .mosi(mosi),
        .miso(miso_b), .miso_oe(oe_b), .tx_data(tx_b), .tx_load(tx_load[1]), .tx_ready(rdy_b),
        .rx_data(rx_b), .rx_valid(rxv_b), .frame_err(ferr_b), .tx_underrun(urun_b));

    spi_slave_core #(.DATA_WIDTH(16), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b0), .SYNC_STAGES(2)) u_c (
        .clock(clock), .reset_n(reset_n), .sclk(sclk), .ss_n(ss_n[2]), .mosi(mosi),
        .miso(miso_c), .miso_oe(oe_c), .tx_data(tx_c), .tx_load(tx_load[2]), .tx_ready(rdy_c),
        .rx_data(rx_c), .rx_valid(rxv_c), .frame_err(ferr_c), .tx_underrun(urun_c));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Output monitor: pulse counters and scoreboard pops.
    always @(negedge clock) begin
        if (rxv_a) begin
            rxv_cnt[0]++;
            if (q_a.size() == 0) check("rx_a_extra", 32'd1, 32'd0);
            else check("rx_a", 32'(rx_a), 32'(q_a.pop_front()));
        end
        if (rxv_b) begin
            rxv_cnt[1]++;
            if (q_b.size() == 0) check("rx_b_extra", 32'd1, 32'd0);
            else check("rx_b", 32'(rx_b), 32'(q_b.pop_front()));
        end
        if (rxv_c) begin
            rxv_cnt[2]++;
            if (q_c.size() == 0) check("rx_c_extra", 32'd1, 32'd0);
            else check("rx_c", 32'(rx_c), 32'(q_c.pop_front()));
        end
        if (ferr_a) ferr_cnt[0]++;
        if (ferr_b) ferr_cnt[1]++;
        if (ferr_c) ferr_cnt[2]++;
        if (urun_a) urun_cnt[0]++;
        if (urun_b) urun_cnt[1]++;
        if (urun_c) urun_cnt[2]++;
    end

    function automatic logic miso_of(input int inst);
        case (inst)
            0:       return miso_a;
            1:       return miso_b;
            default: return miso_c;
        endcase
    endfunction

    function automatic logic oe_of(input int inst);
        case (inst)
            0:       return oe_a;
            1:       return oe_b;
            default: return oe_c;
        endcase
    endfunction

    task automatic load(input int inst, input logic [15:0] d);
        case (inst)
            0:       tx_a = d[7:0];
            1:       tx_b = d[7:0];
            default: tx_c = d;
        endcase
        tx_load[inst] = 1'b1;
        @(negedge clock);
        tx_load[inst] = 1'b0;
    endtask

    task automatic ss_assert(input int inst, input bit cpol);
        sclk = cpol;
        repeat (4) @(negedge clock);
        ss_n[inst] = 1'b0;
        repeat (HALF) @(negedge clock);
    endtask

    task automatic ss_release(input int inst);
        ss_n[inst] = 1'b1;
        repeat (HALF) @(negedge clock);
    endtask

    // Master side of one word (or nbits of it); captures miso at the
    // master's sample edge.
    task automatic xfer(input int inst, input int w, input bit cpol, input bit cpha,
                        input bit msb, input logic [15:0] tx, input int nbits,
                        output logic [15:0] rx);
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            int b;
            b = msb ? (w - 1 - i) : i;
            if (!cpha) begin
                mosi = tx[b];
                repeat (HALF) @(negedge clock);
                rx[b] = miso_of(inst);
                check("miso_oe", 32'(oe_of(inst)), 32'd1);
                sclk = ~cpol;
                repeat (HALF) @(negedge clock);
                sclk = cpol;
            end else begin
                repeat (HALF) @(negedge clock);
                sclk = ~cpol;
                mosi = tx[b];
                repeat (HALF) @(negedge clock);
                rx[b] = miso_of(inst);
                check("miso_oe", 32'(oe_of(inst)), 32'd1);
                sclk = cpol;
            end
        end
        repeat (HALF) @(negedge clock);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] got;
        int          rv0, fe0, ur0;

        for (int k = 0; k < 3; k++) begin
            rxv_cnt[k]  = 0;
            ferr_cnt[k] = 0;
            urun_cnt[k] = 0;
        end

        // Reset values
        repeat (3) @(negedge clock);
        check("rst_ready_a", 32'(rdy_a), 32'd1);
        check("rst_oe_a",    32'(oe_a),  32'd0);
        check("rst_miso_a",  32'(miso_a), 32'd0);
        check("rst_rx_a",    32'(rx_a),  32'd0);
        check("rst_ready_b", 32'(rdy_b), 32'd1);
        check("rst_ready_c", 32'(rdy_c), 32'd1);
        reset_n = 1'b1;
        repeat (4) @(negedge clock);

        // Mode 0 basic frame: hold 0xA5, master sends 0x3C
        load(0, 16'h00A5);
        check("t1_ready_lo", 32'(rdy_a), 32'd0);
        rv0 = rxv_cnt[0];
        fe0 = ferr_cnt[0];
        q_a.push_back(16'h003C);
        ss_assert(0, 1'b0);
        check("t1_ready_hi", 32'(rdy_a), 32'd1);
        xfer(0, 8, 1'b0, 1'b0, 1'b1, 16'h003C, 8, got);
        ss_release(0);
        check("t1_miso", 32'(got[7:0]), 32'h0A5);
        check("t1_rxv_cnt", 32'(rxv_cnt[0] - rv0), 32'd1);
        check("t1_ferr", 32'(ferr_cnt[0] - fe0), 32'd0);
        check("t1_oe_idle", 32'(oe_a), 32'd0);

        // Mode 3 back-to-back frames in one ss_n low period
        load(1, 16'h0096);
        rv0 = rxv_cnt[1];
        q_b.push_back(16'h0012);
        q_b.push_back(16'h00F0);
        ss_assert(1, 1'b1);
        load(1, 16'h003B);
        xfer(1, 8, 1'b1, 1'b1, 1'b1, 16'h0012, 8, got);
        check("t2_miso0", 32'(got[7:0]), 32'h096);
        xfer(1, 8, 1'b1, 1'b1, 1'b1, 16'h00F0, 8, got);
        check("t2_miso1", 32'(got[7:0]), 32'h03B);
        ss_release(1);
        check("t2_rxv_cnt", 32'(rxv_cnt[1] - rv0), 32'd2);
        check("t2_rx_last", 32'(rx_b), 32'h0F0);
        check("t2_ferr", 32'(ferr_cnt[1]), 32'd0);

        // Frame start with empty holding register
        ur0 = urun_cnt[0];
        q_a.push_back(16'h00C3);
        ss_assert(0, 1'b0);
        check("t3_underrun", 32'(urun_cnt[0] - ur0), 32'd1);
        xfer(0, 8, 1'b0, 1'b0, 1'b1, 16'h00C3, 8, got);
        ss_release(0);
        check("t3_miso_zero", 32'(got[7:0]), 32'h000);

        // Abort after 5 bits, then a clean 0x81 frame
        load(0, 16'h0077);
        rv0 = rxv_cnt[0];
        fe0 = ferr_cnt[0];
        ss_assert(0, 1'b0);
        xfer(0, 8, 1'b0, 1'b0, 1'b1, 16'h0055, 5, got);
        ss_release(0);
        check("t4_partial_miso", 32'(got[7:3]), 32'h0E);
        check("t4_ferr", 32'(ferr_cnt[0] - fe0), 32'd1);
        check("t4_rx_kept", 32'(rx_a), 32'h0C3);
        check("t4_no_rxv", 32'(rxv_cnt[0] - rv0), 32'd0);
        load(0, 16'h0024);
        q_a.push_back(16'h0081);
        ss_assert(0, 1'b0);
        xfer(0, 8, 1'b0, 1'b0, 1'b1, 16'h0081, 8, got);
        ss_release(0);
        check("t4_miso", 32'(got[7:0]), 32'h024);
        check("t4_rx_after", 32'(rx_a), 32'h081);

        // 16-bit LSB-first frame
        load(2, 16'hBEEF);
        q_c.push_back(16'h1234);
        ss_assert(2, 1'b0);
        xfer(2, 16, 1'b0, 1'b0, 1'b0, 16'h1234, 16, got);
        ss_release(2);
        check("t5_miso", 32'(got), 32'hBEEF);
        check("t5_rx", 32'(rx_c), 32'h1234);

        // Reset mid-frame, then a clean frame
        load(0, 16'h0099);
        rv0 = rxv_cnt[0];
        ss_assert(0, 1'b0);
        xfer(0, 8, 1'b0, 1'b0, 1'b1, 16'h00AA, 4, got);
        reset_n = 1'b0;
        #1;
        check("t6_oe", 32'(oe_a), 32'd0);
        check("t6_ready", 32'(rdy_a), 32'd1);
        check("t6_rx_rst", 32'(rx_a), 32'd0);
        ss_n[0] = 1'b1;
        sclk = 1'b0;
        repeat (4) @(negedge clock);
        reset_n = 1'b1;
        repeat (4) @(negedge clock);
        check("t6_no_rxv", 32'(rxv_cnt[0] - rv0), 32'd0);
        load(0, 16'h006E);
        q_a.push_back(16'h0042);
        ss_assert(0, 1'b0);
        xfer(0, 8, 1'b0, 1'b0, 1'b1, 16'h0042, 8, got);
        ss_release(0);
        check("t6_miso", 32'(got[7:0]), 32'h06E);
        check("t6_rxv_cnt", 32'(rxv_cnt[0] - rv0), 32'd1);

        repeat (4) @(negedge clock);
        check("q_a_empty", 32'(q_a.size()), 32'd0);
        check("q_b_empty", 32'(q_b.size()), 32'd0);
        check("q_c_empty", 32'(q_c.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
